instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Sequences instruction fetch. Owns the PC register and drives Instruction_Memory through a
//  req/ack handshake, one request outstanding at a time. Buffers fetched words in a small queue
//  and hands them to decode over a valid/ready interface. Branch/jump redirects flush the queue
//  and drop any stale in-flight response. Sits between the PC/branch logic and decode.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset; bits[1:0] must be 0
//  DEPTH     2              queue entries; power of 2, >=2
// PORTS
//  Clock        in   1   single clock; all state updates on posedge
//  Reset        in   1   asynchronous, active-high reset
//  Imem_Req     out  1   registered; fetch request to instruction memory
//  Imem_Addr    out  32  registered; byte address of the request, always 4-aligned
//  Imem_Ack     in   1   memory response; Imem_Data valid this cycle; ignored while Imem_Req=0
//  Imem_Data    in   32  instruction word returned with Imem_Ack
//  Inst_Valid   out  1   queue head valid (= queue not empty)
//  Inst         out  32  queue head instruction
//  Inst_PC      out  32  queue head address
//  Inst_Ready   in   1   decode accepts head; pop when Inst_Valid&&Inst_Ready
//  Redirect     in   1   one-cycle pulse: flush and refetch from Redirect_PC
//  Redirect_PC  in   32  new fetch address; bits[1:0] forced to 0
// BEHAVIOUR
//  Reset (async, immediate): Fetch_PC=RESET_PC; Imem_Req=0; Imem_Addr=RESET_PC; queue empty;
//   Inst_Valid=0; Inst=0; Inst_PC=0; state IDLE. Reset mid-request abandons it without waiting for ack.
//  Outputs come only from registers/queue storage; no combinational input->output path.
//  Memory protocol: once Imem_Req=1, Imem_Req and Imem_Addr stay constant until the edge that
//   samples Imem_Ack=1. A combinational memory is used with Imem_Ack tied to Imem_Req.
//  Definitions: pop = Inst_Valid&&Inst_Ready; push = state WAIT && Imem_Ack && !Redirect;
//   cnt_next = cnt + push - pop (0..DEPTH).
//  FSM states:
//   IDLE: no request outstanding. If cnt_next<DEPTH: Imem_Req<=1, Imem_Addr<=Fetch_PC, go WAIT.
//   WAIT: request outstanding. On Imem_Ack: write {Imem_Addr, Imem_Data} at queue tail;
//    Fetch_PC<=Fetch_PC+4 (mod 2^32 wrap).
//    If cnt_next<DEPTH: stay WAIT with Imem_Addr<=Fetch_PC+4 and Imem_Req held at 1
//     (back-to-back issue, 1 instr/cycle).
//    Else: Imem_Req<=0, go IDLE.
//   DROP: stale request outstanding. Imem_Req and Imem_Addr held. On Imem_Ack: discard data;
//    Imem_Addr<=Fetch_PC; Imem_Req stays 1; go WAIT.
//  Redirect (priority over everything except Reset), at the sampling edge:
//   Fetch_PC<={Redirect_PC[31:2],2'b00}; queue cleared (cnt=0). A same-cycle pop is still
//   consumed by decode; a same-cycle push is discarded.
//   IDLE: Imem_Req<=1, Imem_Addr<=new PC, go WAIT.
//   WAIT with Imem_Ack: response discarded; Imem_Addr<=new PC; go WAIT.
//   WAIT without Imem_Ack: go DROP.
//   DROP: update Fetch_PC only; stay DROP.
//  Queue: circular buffer, wrapping head/tail pointers. Full: no push, because issue is gated
//   by cnt_next. Empty: Inst_Valid=0. Inst and Inst_PC are don't-care when Inst_Valid=0.
//   Simultaneous push and pop at full or empty is legal and preserves order.
//  Latency: with Imem_Ack=Imem_Req, the first Inst_Valid is 2 cycles after Reset falls and
//   2 cycles after a Redirect.
// TESTING
//  1 RESET_PC=0, Ack=Req, Ready=1 -> Imem_Addr 0,4,8,...; Inst_PC 0,4,8 on consecutive
//    cycles; no gaps.
//  2 Ack=Req, Ready=0 -> exactly 2 entries (PC 0,4) queued, then Imem_Req=0. Raise Ready ->
//    pops 0,4; fetch resumes at 8.
//  3 Ack 3 cycles after Req -> Req/Addr stable 3 cycles; one instruction per 4 cycles;
//    Inst_PC 0,4,8 in order.
//  4 Redirect to 0x100 while 0x8 outstanding, ack 2 cycles later -> DROP; Addr stays 0x8 until
//    ack; data never appears. Next Addr=0x100; first Inst_PC=0x100.
//  5 Queue holding PC 0,4; Redirect with Redirect_PC=0x103 -> Inst_Valid=0 next cycle;
//    refetch from 0x100; back-to-back redirects -> last target wins.
//  6 Assert Reset mid-WAIT -> Imem_Req=0, Inst_Valid=0, Imem_Addr=RESET_PC immediately.
//    After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: owns the fetch PC, issues one outstanding
// instruction-memory request at a time, buffers returned words in a small
// circular queue for decode, and flushes/refetches on branch redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t           state;
  logic [31:0]      fetch_pc;
  logic [31:0]      q_inst [DEPTH];
  logic [31:0]      q_pc   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             pop;
  logic             push;
  logic             can_issue;
  logic [31:0]      target_pc;
  logic [31:0]      next_pc;

  // Queue head is presented straight from storage; valid means non-empty.
  assign inst_valid = (cnt != '0);
  assign inst       = q_inst[head];
  assign inst_pc    = q_pc[head];

  // Handshake decode, occupancy look-ahead and address arithmetic.
  always_comb begin
    pop       = inst_valid && inst_ready;
    push      = (state == S_WAIT) && imem_ack && !redirect;
    cnt_next  = CNT_W'(cnt + CNT_W'(push) - CNT_W'(pop));
    can_issue = (cnt_next < CNT_W'(DEPTH));
    target_pc = redirect_pc & 32'hFFFF_FFFC;
    next_pc   = 32'(fetch_pc + 32'd4);
  end

  // Fetch FSM, PC, request outputs and queue storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      if (push) begin
        q_inst[tail] <= imem_data;
        q_pc[tail]   <= imem_addr;
      end
      if (redirect) begin
        // Flush and retarget; a stale request in flight must be drained first.
        fetch_pc <= target_pc;
        cnt      <= '0;
        head     <= '0;
        tail     <= '0;
        case (state)
          S_IDLE: begin
            imem_req  <= 1'b1;
            imem_addr <= target_pc;
            state     <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_ack) imem_addr <= target_pc;
            else          state     <= S_DROP;
          end
          default: ;
        endcase
      end else begin
        cnt  <= cnt_next;
        head <= head + PTR_W'(pop);
        if (push) tail <= tail + PTR_W'(1);
        case (state)
          S_IDLE: begin
            if (can_issue) begin
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc;
              state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_ack) begin
              fetch_pc <= next_pc;
              if (can_issue) begin
                imem_addr <= next_pc;
              end else begin
                imem_req <= 1'b0;
                state    <= S_IDLE;
              end
            end
          end
          S_DROP: begin
            if (imem_ack) begin
              imem_addr <= fetch_pc;
              state     <= S_WAIT;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
